// File: rtl/host_command_pkg.sv
// Shared types and constants for the host command serializer: opcodes, protocol
// command bytes, FSM state types and the per-opcode byte count.
package host_command_pkg;

  typedef enum logic [1:0] {
    OpWrite  = 2'd0,
    OpRead   = 2'd1,
    OpAluOp  = 2'd2,
    OpAluNop = 2'd3
  } opcode_e;

  localparam logic [7:0] CmdByteWrite  = 8'hAA;
  localparam logic [7:0] CmdByteRead   = 8'hBB;
  localparam logic [7:0] CmdByteAluOp  = 8'hCC;
  localparam logic [7:0] CmdByteAluNop = 8'hDD;

  // Character-level states of the UART shifter.
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  // Frame-level states of the byte sequencer.
  typedef enum logic [1:0] {
    SeqIdle,
    SeqSend,
    SeqDone
  } seq_state_e;

  function automatic logic [2:0] byte_count(opcode_e op);
    case (op)
      OpWrite: return 3'd3;
      OpRead:  return 3'd2;
      OpAluOp: return 3'd4;
      default: return 3'd2;
    endcase
  endfunction

endpackage

// File: rtl/host_command_serializer_uart_byte_tx.sv
// UART character shifter: start bit, LSB-first data, optional parity, one stop bit.
// A new byte is taken at the end of a stop bit when byte_valid is high, so characters abut.
module uart_byte_tx
  import host_command_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BAUD_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  byte_valid,
  input  logic [DATA_WIDTH-1:0] byte_data,
  output logic                  byte_done,
  input  logic [BAUD_WIDTH-1:0] baud_div,
  input  logic                  par_en,
  input  logic                  par_type,
  input  logic                  par_flip,
  input  logic                  stop_low,
  output logic                  ser_data_out
);

  localparam int unsigned BitW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_WIDTH - 1);

  tx_state_e             state_q, state_d;
  logic [BAUD_WIDTH-1:0] cnt_q, cnt_d, div_eff;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ser_q, ser_d;
  logic                  bit_end;

  assign div_eff = (baud_div == '0) ? BAUD_WIDTH'(1) : baud_div;
  assign bit_end = (cnt_q == div_eff - BAUD_WIDTH'(1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    data_d    = data_q;
    byte_done = 1'b0;
    if (state_q != StIdle) cnt_d = bit_end ? '0 : cnt_q + BAUD_WIDTH'(1);
    case (state_q)
      StIdle: begin
        if (byte_valid) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        // Byte is captured at the end of the start bit, once the sequencer has its fields latched.
        if (bit_end) begin
          state_d = StData;
          bit_d   = '0;
          data_d  = byte_data;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_q == LastBit) state_d = par_en ? StParity : StStop;
          else                  bit_d   = bit_q + BitW'(1);
        end
      end
      StParity: if (bit_end) state_d = StStop;
      StStop: begin
        if (bit_end) begin
          byte_done = 1'b1;
          state_d   = byte_valid ? StStart : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level registered from the next state so each bit starts exactly on its state entry.
  always_comb begin
    case (state_d)
      StStart:  ser_d = 1'b0;
      StData:   ser_d = data_d[bit_d];
      StParity: ser_d = (^data_q) ^ par_type ^ par_flip;
      StStop:   ser_d = ~stop_low;
      default:  ser_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      ser_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      ser_q   <= ser_d;
    end
  end

  assign ser_data_out = ser_q;

endmodule

// File: rtl/host_command_serializer.sv
// Host command serializer: latches one command and sends its protocol bytes as UART characters.
// Optional HOST_CMD_ERROR_INJECT_EN adds parity/stop-bit error injection inputs.
module host_command_serializer
  import host_command_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned BAUD_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_opcode,
  input  logic [ADDR_WIDTH-1:0] cmd_address,
  input  logic [DATA_WIDTH-1:0] cmd_data_a,
  input  logic [DATA_WIDTH-1:0] cmd_data_b,
  input  logic [3:0]            cmd_function,
  input  logic                  par_en,
  input  logic                  par_type,
  input  logic [BAUD_WIDTH-1:0] baud_div,
`ifdef HOST_CMD_ERROR_INJECT_EN
  input  logic                  inject_par_err,
  input  logic                  inject_frame_err,
`endif
  output logic                  ser_data_out,
  output logic                  busy,
  output logic                  frame_done
);

  seq_state_e            seq_q, seq_d;
  logic [1:0]            byte_idx_q, byte_idx_d, last_idx;
  opcode_e               op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_a_q, data_b_q, byte_data;
  logic [3:0]            fn_q;
  logic                  par_en_q, par_type_q;
  logic [BAUD_WIDTH-1:0] baud_q;
  logic                  accept, is_last, byte_valid, byte_done, par_flip, stop_low;

  assign accept   = (seq_q == SeqIdle) && cmd_valid;
  assign last_idx = 2'(byte_count(op_q) - 3'd1);
  assign is_last  = (byte_idx_q == last_idx);
  // Offered on acceptance, and thereafter as long as bytes remain behind the current one.
  assign byte_valid = accept || ((seq_q == SeqSend) && !is_last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q       <= OpWrite;
      addr_q     <= '0;
      data_a_q   <= '0;
      data_b_q   <= '0;
      fn_q       <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      baud_q     <= '0;
    end else if (accept) begin
      op_q       <= opcode_e'(cmd_opcode);
      addr_q     <= cmd_address;
      data_a_q   <= cmd_data_a;
      data_b_q   <= cmd_data_b;
      fn_q       <= cmd_function;
      par_en_q   <= par_en;
      par_type_q <= par_type;
      baud_q     <= baud_div;
    end
  end

`ifdef HOST_CMD_ERROR_INJECT_EN
  logic inj_par_q, inj_frame_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inj_par_q   <= 1'b0;
      inj_frame_q <= 1'b0;
    end else if (accept) begin
      inj_par_q   <= inject_par_err;
      inj_frame_q <= inject_frame_err;
    end
  end
  assign par_flip = inj_par_q;
  assign stop_low = inj_frame_q && is_last;
`else
  assign par_flip = 1'b0;
  assign stop_low = 1'b0;
`endif

  always_comb begin
    byte_data = '0;
    case (op_q)
      OpWrite: begin
        case (byte_idx_q)
          2'd0:    byte_data = DATA_WIDTH'(CmdByteWrite);
          2'd1:    byte_data = DATA_WIDTH'(addr_q);
          default: byte_data = data_a_q;
        endcase
      end
      OpRead: byte_data = (byte_idx_q == 2'd0) ? DATA_WIDTH'(CmdByteRead) : DATA_WIDTH'(addr_q);
      OpAluOp: begin
        case (byte_idx_q)
          2'd0:    byte_data = DATA_WIDTH'(CmdByteAluOp);
          2'd1:    byte_data = data_a_q;
          2'd2:    byte_data = data_b_q;
          default: byte_data = DATA_WIDTH'(fn_q);
        endcase
      end
      default: byte_data = (byte_idx_q == 2'd0) ? DATA_WIDTH'(CmdByteAluNop) : DATA_WIDTH'(fn_q);
    endcase
  end

  always_comb begin
    seq_d      = seq_q;
    byte_idx_d = byte_idx_q;
    case (seq_q)
      SeqIdle: if (cmd_valid) seq_d = SeqSend;
      SeqSend: begin
        if (byte_done) begin
          if (is_last) seq_d      = SeqDone;
          else         byte_idx_d = byte_idx_q + 2'd1;
        end
      end
      SeqDone: begin
        seq_d      = SeqIdle;
        byte_idx_d = '0;
      end
      default: seq_d = SeqIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seq_q      <= SeqIdle;
      byte_idx_q <= '0;
    end else begin
      seq_q      <= seq_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  assign cmd_ready  = (seq_q == SeqIdle);
  assign busy       = (seq_q == SeqSend);
  assign frame_done = (seq_q == SeqDone);

  uart_byte_tx #(
    .DATA_WIDTH(DATA_WIDTH),
    .BAUD_WIDTH(BAUD_WIDTH)
  ) u_tx (
    .clk         (clk),
    .reset_n     (reset_n),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_done   (byte_done),
    .baud_div    (baud_q),
    .par_en      (par_en_q),
    .par_type    (par_type_q),
    .par_flip    (par_flip),
    .stop_low    (stop_low),
    .ser_data_out(ser_data_out)
  );

endmodule
